csr_uart_tx: RTL and testbench

//  CSR-mapped UART transmitter that sits on the PolarisCPU CSR bus beside output_csr.

---
 rtl/csr_uart_tx.sv | 178 +++++++++++++++++
 tb/tb_csr_uart_tx.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers in front of a byte FIFO.
// Optional TX-empty interrupt (irq_o, STATUS[8] IE) is built when CSR_UART_TX_IRQ_EN is defined.
module csr_uart_tx #(
  parameter logic [11:0] BASE_ADDR = 12'h7F0,
  parameter int          FIFO_AW   = 3,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [11:0] cadr_i,
  input  logic        coe_i,
  input  logic        cwe_i,
  input  logic [63:0] cdat_i,
  output logic [63:0] cdat_o,
  output logic        cvalid_o,
  output logic        txd_o
`ifdef CSR_UART_TX_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // Bus handshake: cvalid_o flags an address hit regardless of strobes; reads are
  // combinational during coe_i, writes commit on the clock edge with cwe_i.
  logic [11:0] offs;
  logic        hit_tx, hit_st, hit_div;
  logic        wr_tx, wr_st, wr_div;

  assign offs     = cadr_i - BASE_ADDR;
  assign hit_tx   = (offs == 12'd0);
  assign hit_st   = (offs == 12'd1);
  assign hit_div  = (offs == 12'd2);
  assign cvalid_o = hit_tx | hit_st | hit_div;
  assign wr_tx    = hit_tx & cwe_i;
  assign wr_st    = hit_st & cwe_i;
  assign wr_div   = hit_div & cwe_i;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, push, pop, ovr;
  logic [15:0]        divisor, period_m1, cnt;
  logic [7:0]         shreg;
  logic [2:0]         bitidx;
  logic               bit_end, busy, ie;
  state_t             state;

  assign full      = (count == (FIFO_AW + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign bit_end   = (cnt == 16'd0);
  assign busy      = (state != ST_IDLE);
  assign period_m1 = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
  assign pop       = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push      = wr_tx & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= cdat_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ovr     <= 1'b0;
      divisor <= DIV_RESET;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_tx & full & ~pop)  ovr <= 1'b1;
      else if (wr_st & cdat_i[3]) ovr <= 1'b0;
      if (wr_div) divisor <= cdat_i[15:0];
    end
  end

`ifdef CSR_UART_TX_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ie    <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr_st) ie <= cdat_i[8];
      irq_o <= ie & empty & ~busy;
    end
  end
`else
  assign ie = 1'b0;
`endif

  // txd_o follows the state of the previous cycle, so each line level lasts one bit period.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= ST_IDLE;
      txd_o  <= 1'b1;
      cnt    <= 16'd0;
      bitidx <= 3'd0;
      shreg  <= 8'd0;
    end else begin
      case (state)
        ST_START: txd_o <= 1'b0;
        ST_DATA:  txd_o <= shreg[0];
        default:  txd_o <= 1'b1;
      endcase
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg <= mem[rptr];
            cnt   <= period_m1;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt    <= period_m1;
            bitidx <= 3'd0;
            state  <= ST_DATA;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt    <= period_m1;
            shreg  <= shreg >> 1;
            bitidx <= bitidx + 3'd1;
            if (bitidx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shreg <= mem[rptr];
              cnt   <= period_m1;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [63:0] status_word;
  logic        unused_bits;
  assign unused_bits = ^{cdat_i[63:16], cdat_i[8]};

  always_comb begin
    status_word                  = 64'h0;
    status_word[0]               = full;
    status_word[1]               = empty;
    status_word[2]               = busy;
    status_word[3]               = ovr;
    status_word[8]               = ie;
    status_word[16 +: FIFO_AW+1] = count;
    cdat_o = 64'h0;
    if (coe_i) begin
      if (hit_st)  cdat_o = status_word;
      if (hit_div) cdat_o[15:0] = divisor;
    end
  end

endmodule

// File: tb/tb_csr_uart_tx.sv
// Bench for csr_uart_tx: a frame-schedule model of the serial line checked every cycle,
// plus directed CSR reads with literal expectations. Define CSR_UART_TX_IRQ_EN for the IRQ build.
module tb_csr_uart_tx;

  localparam logic [11:0] A_TX  = 12'h7F0;
  localparam logic [11:0] A_ST  = 12'h7F1;
  localparam logic [11:0] A_DIV = 12'h7F2;
  localparam logic [11:0] A_BAD = 12'h7F3;
  localparam int BIG   = 1 << 30;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] cadr = A_ST;
  logic        coe = 1'b0;
  logic        cwe = 1'b0;
  logic [63:0] cdat_w = 64'h0;
  logic [63:0] cdat_r;
  logic        cvalid;
  logic        txd;
`ifdef CSR_UART_TX_IRQ_EN
  logic        irq;
`endif

  csr_uart_tx dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .cadr_i   (cadr),
    .coe_i    (coe),
    .cwe_i    (cwe),
    .cdat_i   (cdat_w),
    .cdat_o   (cdat_r),
    .cvalid_o (cvalid),
    .txd_o    (txd)
`ifdef CSR_UART_TX_IRQ_EN
    ,
    .irq_o    (irq)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- line model ----------------
  // Each accepted byte becomes a frame: it starts 2 edges after its push or right when the
  // previous frame ends; it occupies 10 bit periods. Reset truncates every frame.
  typedef struct {
    int push; int pop; int start; int fend; int bend; int kill; int p;
    logic [7:0] data;
  } frame_t;
  frame_t fr[$];
  int   model_div = 434;
  logic model_ovr = 1'b0;
  int   ie_on = BIG;
  int   ie_off = BIG;
  int   rst_r = 0;
  int   last_wr = 0;

  function automatic logic model_txd(input int t);
    int k;
    foreach (fr[i]) begin
      if (fr[i].start <= t && t < fr[i].fend) begin
        k = (t - fr[i].start) / fr[i].p;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fr[i].data[k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic model_busy(input int t);
    foreach (fr[i]) if (fr[i].pop <= t && t < fr[i].bend) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_count(input int t);
    int n = 0;
    foreach (fr[i]) if (fr[i].push <= t && t < fr[i].pop && t < fr[i].kill) n++;
    return n;
  endfunction

  function automatic logic ie_at(input int t);
    return (t >= ie_on) && (t < ie_off);
  endfunction

  function automatic logic model_irq(input int t);
    return (t != rst_r) && ie_at(t - 1) && (model_count(t - 1) == 0) && !model_busy(t - 1);
  endfunction

  function automatic logic [63:0] model_status(input int t);
    logic [63:0] s;
    int c;
    c = model_count(t);
    s = 64'h0;
    s[0] = (c == DEPTH);
    s[1] = (c == 0);
    s[2] = model_busy(t);
    s[3] = model_ovr;
`ifdef CSR_UART_TX_IRQ_EN
    s[8] = ie_at(t);
`endif
    s[19:16] = 4'(c);
    return s;
  endfunction

  task automatic model_push(input logic [7:0] d, input int n);
    int occ = 0;
    int last = 0;
    frame_t f;
    foreach (fr[i]) begin
      if (fr[i].pop > n && fr[i].kill > n) occ++;
      if (fr[i].fend > last) last = fr[i].fend;
    end
    if (occ >= DEPTH) begin
      model_ovr = 1'b1;
    end else begin
      f.p     = (model_div == 0) ? 1 : model_div;
      f.push  = n;
      f.start = (n + 2 > last) ? n + 2 : last;
      f.pop   = f.start - 1;
      f.fend  = f.start + 10 * f.p;
      f.bend  = f.start - 1 + 10 * f.p;
      f.kill  = BIG;
      f.data  = d;
      fr.push_back(f);
    end
  endtask

  task automatic model_write(input logic [11:0] a, input logic [63:0] d, input int n);
    if (a == A_TX) model_push(d[7:0], n);
    if (a == A_ST) begin
      if (d[3]) model_ovr = 1'b0;
`ifdef CSR_UART_TX_IRQ_EN
      if (d[8] && !(ie_on != BIG && ie_off == BIG)) begin
        ie_on = n;
        ie_off = BIG;
      end else if (!d[8] && ie_on != BIG && ie_off == BIG) begin
        ie_off = n;
      end
`endif
    end
    if (a == A_DIV) model_div = int'(d[15:0]);
  endtask

  task automatic model_reset(input int r);
    foreach (fr[i]) begin
      if (fr[i].fend > r) fr[i].fend = r;
      if (fr[i].bend > r) fr[i].bend = r;
      if (fr[i].kill > r) fr[i].kill = r;
    end
    model_ovr = 1'b0;
    model_div = 434;
    if (ie_on != BIG && ie_off > r) ie_off = r;
    rst_r = r;
  endtask

  function automatic int model_idle_at();
    int e = 0;
    foreach (fr[i]) if (fr[i].fend > e) e = fr[i].fend;
    return e;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check64("txd", {63'h0, txd}, {63'h0, model_txd(cyc)});
`ifdef CSR_UART_TX_IRQ_EN
      check64("irq", {63'h0, irq}, {63'h0, model_irq(cyc)});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    int n;
    @(negedge clk);
    n = cyc + 1;
    cadr = a;
    cdat_w = d;
    cwe = 1'b1;
    model_write(a, d, n);
    last_wr = n;
    @(posedge clk);
    #1;
    cwe = 1'b0;
    cdat_w = 64'h0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [63:0] d, output logic v,
                          output int t);
    @(negedge clk);
    cadr = a;
    coe = 1'b1;
    #1;
    d = cdat_r;
    v = cvalid;
    t = cyc;
    coe = 1'b0;
  endtask

  task automatic read_status(input string name);
    logic [63:0] d;
    logic v;
    int t;
    csr_read(A_ST, d, v, t);
    check64({name, "_valid"}, {63'h0, v}, 64'h1);
    check64(name, d, model_status(t));
  endtask

  task automatic read_literal(input string name, input logic [11:0] a, input logic [63:0] exp);
    logic [63:0] d;
    logic v;
    int t;
    csr_read(a, d, v, t);
    check64(name, d, exp);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset = 1'b1;
    model_reset(cyc + 1);
    repeat (ncyc) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic watch_frame(input int nb, output logic [63:0] bits, output int lat);
    int w = 0;
    bits = 64'h0;
    lat = -1;
    while (w < 200) begin
      @(negedge clk);
      if (txd === 1'b0) break;
      w++;
    end
    check64("start_seen", {63'h0, (w < 200)}, 64'h1);
    lat = cyc - last_wr;
    bits = {bits[62:0], txd};
    repeat (nb - 1) begin
      @(negedge clk);
      bits = {bits[62:0], txd};
    end
  endtask

  task automatic wait_idle();
    int e;
    e = model_idle_at();
    if (e > cyc) repeat (e - cyc + 3) @(negedge clk);
    else repeat (3) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] bits;
    logic [63:0] d;
    logic v;
    int lat;
    int t;

    // 1: reset state and address decode
    @(posedge clk);
    #1;
    check64("cvalid_in_reset", {63'h0, cvalid}, 64'h1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rst_r = 3;
    chk_en = 1'b1;
    read_literal("status_reset", A_ST, 64'h0000_0000_0000_0002);
    read_status("status_reset_model");
    read_literal("div_reset", A_DIV, 64'd434);
    read_literal("txdata_reads_0", A_TX, 64'h0);
    csr_read(A_BAD, d, v, t);
    check64("bad_addr_valid", {63'h0, v}, 64'h0);
    check64("bad_addr_data", d, 64'h0);
    @(negedge clk);
    cadr = A_DIV;
    coe = 1'b0;
    #1;
    check64("no_oe_data", cdat_r, 64'h0);
    check64("no_oe_valid", {63'h0, cvalid}, 64'h1);
    check64("txd_idle", {63'h0, txd}, 64'h1);

    // 2: single 0x55 frame at 4 cycles per bit
    csr_write(A_DIV, 64'd4);
    read_literal("div_4", A_DIV, 64'd4);
    csr_write(A_TX, 64'h55);
    watch_frame(40, bits, lat);
    check64("lat_55", 64'(lat), 64'd2);
    check64("bits_55", {24'h0, bits[39:0]}, 64'h0000_000F_0F0F_0F0F);
    read_literal("status_after_55", A_ST, 64'h0000_0000_0000_0002);

    // 3: fill FIFO behind a running frame, overflow, clear OVR
    csr_write(A_DIV, 64'd2);
    for (int i = 0; i < 9; i++) csr_write(A_TX, 64'(8'h30 + i));
    read_literal("status_full", A_ST, 64'h0000_0000_0008_0005);
    read_status("status_full_model");
    csr_write(A_TX, 64'hEE);
    read_literal("status_ovr", A_ST, 64'h0000_0000_0008_000D);
    csr_write(A_ST, 64'h8);
    read_literal("status_ovr_clr", A_ST, 64'h0000_0000_0008_0005);
    wait_idle();
    read_status("status_drained");

    // 4: back-to-back frames, DIVISOR 0 behaves as 1
    csr_write(A_DIV, 64'd0);
    read_literal("div_0", A_DIV, 64'd0);
    csr_write(A_TX, 64'hA0);
    csr_write(A_TX, 64'h0F);
    last_wr = last_wr - 1;
    watch_frame(20, bits, lat);
    check64("lat_a0", 64'(lat), 64'd2);
    check64("bits_a0_0f", {44'h0, bits[19:0]}, 64'h0000_0000_0000_2DE1 & 64'hF_FFFF | 64'h0_2DE1);
    wait_idle();
    read_status("status_after_pair");

    // 5: reset in the middle of a frame drops it and the queued byte
    csr_write(A_DIV, 64'd2);
    csr_write(A_TX, 64'hFF);
    csr_write(A_TX, 64'h81);
    repeat (8) @(negedge clk);
    do_reset(1);
    @(negedge clk);
    check64("txd_after_reset", {63'h0, txd}, 64'h1);
    read_literal("status_after_reset", A_ST, 64'h0000_0000_0000_0002);
    read_status("status_after_reset_model");
    read_literal("div_after_reset", A_DIV, 64'd434);
    repeat (30) @(negedge clk);

`ifdef CSR_UART_TX_IRQ_EN
    // 6: TX-empty interrupt
    csr_write(A_DIV, 64'd2);
    csr_write(A_ST, 64'h100);
    repeat (2) @(negedge clk);
    check64("irq_idle", {63'h0, irq}, 64'h1);
    read_literal("status_ie", A_ST, 64'h0000_0000_0000_0102);
    csr_write(A_TX, 64'h3C);
    @(negedge clk);
    check64("irq_busy", {63'h0, irq}, 64'h0);
    wait_idle();
    check64("irq_done", {63'h0, irq}, 64'h1);
    read_status("status_ie_model");
`else
    csr_write(A_ST, 64'h100);
    read_literal("status_ie_ignored", A_ST, 64'h0000_0000_0000_0002);
`endif
    csr_read(A_BAD, d, v, t);
    check64("bad_addr_valid_end", {63'h0, v}, 64'h0);
    check64("bad_addr_data_end", d, 64'h0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
